// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: control sequencer for one matrix-multiply pass.
// It gates host row loads into the A/B skew banks, tracks which rows
// are present, then drives mem_en for exactly RUN_CYCLES to stream the
// skewed operands through the array, and finishes with a done pulse.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, abort             pass request (IDLE only) / sync abort
//   ld_valid, ld_sel, ld_row host row load (sel 0=A, 1=B)
//   ld_ready                 load handshake, high in LOAD
//   memA_WrEn/row, memB_*    combinational bank write strobes/rows
//   mem_en, sys_clr          bank/array shift enable, acc clear
//   busy, done, run_cnt      status, completion pulse, compute index
module systolic_seq_ctrl #(
    parameter int DIM   = 8,
    parameter int CNT_W = $clog2(3 * DIM),
    localparam int RW   = $clog2(DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             ld_sel,
    input  logic [RW-1:0]    ld_row,
    output logic             memA_WrEn,
    output logic [RW-1:0]    memA_row,
    output logic             memB_WrEn,
    output logic [RW-1:0]    memB_row,
    output logic             mem_en,
    output logic             sys_clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] run_cnt
);

    localparam int RUN_CYCLES = 3 * DIM - 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIM-1:0]   bm_a_q, bm_a_d;
    logic [DIM-1:0]   bm_b_q, bm_b_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             ld_ready_q, ld_ready_d;
    logic             mem_en_q, mem_en_d;
    logic             sys_clr_q, sys_clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fire_a, fire_b;

    // A transfer needs the registered ready, so only LOAD accepts rows.
    assign fire_a = ld_valid & ld_ready_q & ~ld_sel;
    assign fire_b = ld_valid & ld_ready_q & ld_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bm_a_q     <= '0;
            bm_b_q     <= '0;
            run_cnt_q  <= '0;
            ld_ready_q <= 1'b0;
            mem_en_q   <= 1'b0;
            sys_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bm_a_q     <= bm_a_d;
            bm_b_q     <= bm_b_d;
            run_cnt_q  <= run_cnt_d;
            ld_ready_q <= ld_ready_d;
            mem_en_q   <= mem_en_d;
            sys_clr_q  <= sys_clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bm_a_d    = bm_a_q;
        bm_b_d    = bm_b_q;
        run_cnt_d = run_cnt_q;
        if (abort) begin
            state_d   = S_IDLE;
            bm_a_d    = '0;
            bm_b_d    = '0;
            run_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        bm_a_d  = '0;
                        bm_b_d  = '0;
                    end
                end
                S_LOAD: begin
                    if (fire_a) bm_a_d[ld_row] = 1'b1;
                    if (fire_b) bm_b_d[ld_row] = 1'b1;
                    // Decide on the registered maps: ready drops one
                    // cycle after the final load lands.
                    if ((&bm_a_q) && (&bm_b_q)) begin
                        state_d   = S_RUN;
                        run_cnt_d = '0;
                    end
                end
                S_RUN: begin
                    if (run_cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end else begin
                        run_cnt_d = run_cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d   = S_IDLE;
                    run_cnt_d = '0;
                end
            endcase
        end
    end

    // Registered outputs are decoded from the next state so they line
    // up with the state they describe.
    always_comb begin
        ld_ready_d = (state_d == S_LOAD);
        mem_en_d   = (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        sys_clr_d  = (state_q == S_IDLE) && (state_d == S_LOAD);
        memA_WrEn  = fire_a;
        memB_WrEn  = fire_b;
        memA_row   = ld_row;
        memB_row   = ld_row;
    end

    assign ld_ready = ld_ready_q;
    assign mem_en   = mem_en_q;
    assign sys_clr  = sys_clr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign run_cnt  = run_cnt_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: self-checking bench for systolic_seq_ctrl.
// Load vectors come from tables; run_cnt is checked via a scoreboard.
module tb_systolic_seq_ctrl;

    localparam int DIM     = 8;
    localparam int CNT_W   = $clog2(3 * DIM);
    localparam int RUN_LEN = 22;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic             ld_sel = 1'b0;
    logic [2:0]       ld_row = '0;
    logic             memA_WrEn;
    logic [2:0]       memA_row;
    logic             memB_WrEn;
    logic [2:0]       memB_row;
    logic             mem_en;
    logic             sys_clr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] run_cnt;

    systolic_seq_ctrl #(.DIM(DIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_sel    (ld_sel),
        .ld_row    (ld_row),
        .memA_WrEn (memA_WrEn),
        .memA_row  (memA_row),
        .memB_WrEn (memB_WrEn),
        .memB_row  (memB_row),
        .mem_en    (mem_en),
        .sys_clr   (sys_clr),
        .busy      (busy),
        .done      (done),
        .run_cnt   (run_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        bit       start;
        bit       sel;
        bit [2:0] row;
        bit       exp_a;
        bit       exp_b;
    } vec_t;

    vec_t vq[$];
    int   sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(bit v, bit s, bit sel, int row,
                                bit ea, bit eb);
        vec_t r;
        r.valid = v;
        r.start = s;
        r.sel   = sel;
        r.row   = 3'(row);
        r.exp_a = ea;
        r.exp_b = eb;
        return r;
    endfunction

    // Scoreboard: each mem_en cycle must present the next expected index
    // and must never carry a write strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (sb_q.size() == 0) begin
                    chk("extra_mem_en", 1, 0);
                end else begin
                    chk("run_cnt", int'(run_cnt), sb_q.pop_front());
                end
                chk("run_no_wr", int'(memA_WrEn | memB_WrEn), 0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sys_clr_first", int'(sys_clr), 1);
        chk("ld_ready_load", int'(ld_ready), 1);
        chk("busy_load", int'(busy), 1);
    endtask

    task automatic build_full(input int n);
        vq.delete();
        for (int i = 0; i < n; i++)
            vq.push_back(mk(1, 0, i >= 8, i % 8, i < 8, i >= 8));
    endtask

    task automatic do_loads(input bit chk_clr);
        for (int i = 0; i < vq.size(); i++) begin
            ld_valid = vq[i].valid;
            start    = vq[i].start;
            ld_sel   = vq[i].sel;
            ld_row   = vq[i].row;
            @(negedge clk);
            chk("ld_ready", int'(ld_ready), 1);
            chk("memA_WrEn", int'(memA_WrEn), int'(vq[i].exp_a));
            chk("memB_WrEn", int'(memB_WrEn), int'(vq[i].exp_b));
            if (vq[i].exp_a) chk("memA_row", int'(memA_row), int'(vq[i].row));
            if (vq[i].exp_b) chk("memB_row", int'(memB_row), int'(vq[i].row));
            chk("mem_en_load", int'(mem_en), 0);
            tick();
            if (chk_clr && i == 0) chk("sys_clr_once", int'(sys_clr), 0);
        end
        ld_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Entered in the cycle right after the final load.
    task automatic finish_run(input bit disturb);
        int d0;
        d0 = done_cnt;
        chk("ready_after_last", int'(ld_ready), 1);
        chk("mem_en_pre", int'(mem_en), 0);
        for (int k = 0; k < RUN_LEN; k++) sb_q.push_back(k);
        tick();
        chk("ready_run", int'(ld_ready), 0);
        chk("mem_en_run", int'(mem_en), 1);
        if (disturb) begin
            ld_valid = 1'b1;
            ld_sel   = 1'b0;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            start = disturb && (i == 3);
            tick();
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        chk("done_seen", int'(done), 1);
        chk("busy_done", int'(busy), 1);
        chk("mem_en_done", int'(mem_en), 0);
        chk("sb_empty", sb_q.size(), 0);
        sb_q.delete();
        tick();
        chk("done_once", done_cnt - d0, 1);
        chk("busy_idle", int'(busy), 0);
        chk("done_low", int'(done), 0);
        chk("run_cnt_idle", int'(run_cnt), 0);
    endtask

    initial begin
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(ld_ready), 0);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sys_clr", int'(sys_clr), 0);
        chk("rst_run_cnt", int'(run_cnt), 0);
        ld_valid = 1'b1;
        #1;
        chk("rst_wr", int'(memA_WrEn | memB_WrEn), 0);
        ld_valid = 1'b0;
        #9 rst = 1'b0;
        tick();

        // Start and abort together in IDLE: stays IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_ready", int'(ld_ready), 0);

        // Plain pass: A0..7 then B0..7.
        do_start();
        build_full(16);
        do_loads(1);
        finish_run(0);

        // Interleaved loads with gaps, duplicate A3, stray start, B7 last.
        do_start();
        vq.delete();
        vq.push_back(mk(1, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 5, 0, 0));
        vq.push_back(mk(1, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 0, 0, 2, 1, 0));
        vq.push_back(mk(1, 0, 0, 3, 1, 0));
        vq.push_back(mk(1, 0, 0, 3, 1, 0));
        vq.push_back(mk(0, 0, 1, 7, 0, 0));
        for (int r = 1; r < 7; r++) vq.push_back(mk(1, 0, 1, r, 0, 1));
        for (int r = 4; r < 8; r++) vq.push_back(mk(1, 0, 0, r, 1, 0));
        vq.push_back(mk(0, 1, 1, 7, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 7, 0, 1));
        do_loads(1);
        finish_run(1);

        // Abort at run_cnt 10.
        do_start();
        build_full(16);
        do_loads(0);
        for (int k = 0; k < RUN_LEN; k++) sb_q.push_back(k);
        tick();
        for (int i = 0; i < 30 && run_cnt != 10; i++) tick();
        chk("abort_at", int'(run_cnt), 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_mem_en", int'(mem_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(ld_ready), 0);
        chk("abort_cnt", int'(run_cnt), 0);
        chk("abort_left", sb_q.size(), RUN_LEN - 11);
        sb_q.delete();
        begin
            int d0;
            d0 = done_cnt;
            repeat (3) tick();
            chk("abort_no_done", done_cnt - d0, 0);
        end
        do_start();
        build_full(15);
        do_loads(0);
        repeat (3) tick();
        chk("abort_reload_ready", int'(ld_ready), 1);
        chk("abort_reload_run", int'(mem_en), 0);
        vq.delete();
        vq.push_back(mk(1, 0, 1, 7, 0, 1));
        do_loads(0);
        finish_run(0);

        // Async reset mid-LOAD.
        do_start();
        build_full(9);
        do_loads(0);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(ld_ready), 0);
        chk("arst_mem_en", int'(mem_en), 0);
        #2 rst = 1'b0;
        tick();
        do_start();
        build_full(15);
        do_loads(0);
        repeat (3) tick();
        chk("arst_no_run", int'(mem_en), 0);
        chk("arst_still_load", int'(ld_ready), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Back-to-back passes: start right after done.
        do_start();
        build_full(16);
        do_loads(1);
        finish_run(0);
        do_start();
        build_full(16);
        do_loads(1);
        finish_run(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
